mem_arbiter: RTL and testbench

- Upstream of the MMU. Merges the IF-stage instruction fetch and the MEM-stage load/store into the MMU's single access port: one access per clock, data side has priority.
- Produces pipeline stall requests.
- Paces UART transmit stores: a second UART data write is held until the transmitter is idle, or until a timeout expires.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/uart_tx_pacer.sv | 64 ++++++
 rtl/mem_arbiter.sv | 100 ++++++++++
 tb/tb_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the MMU front-end arbiter: grant sources, UART pacing
// states and the UART address decode.
package mem_pkg;
  typedef enum logic [1:0] {
    GNT_IDLE  = 2'd0,
    GNT_FETCH = 2'd1,
    GNT_DATA  = 2'd2
  } grant_e;

  typedef enum logic {
    UART_IDLE = 1'b0,
    UART_BUSY = 1'b1
  } uart_state_e;

  localparam int UART_SEL_BIT  = 29;  // device select
  localparam int UART_STAT_BIT = 2;   // status register (vs data register)

  function automatic logic is_uart_data(input logic [31:0] addr);
    return addr[UART_SEL_BIT] & ~addr[UART_STAT_BIT];
  endfunction
endpackage

// File: rtl/uart_tx_pacer.sv
// Holds back a UART data store while the transmitter is still busy with the
// previous byte, giving up after UART_TIMEOUT cycles and flagging that it did.
module uart_tx_pacer
  import mem_pkg::*;
#(
  parameter int UART_TIMEOUT = 1024,
  parameter int CNT_W        = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic uart_store,
  input  logic uart_tbre,
  input  logic uart_tsre,
  output logic blocked,
  output logic uart_timeout
);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(UART_TIMEOUT);

  uart_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             tmo_nxt, ready, go;

  assign ready   = uart_tbre & uart_tsre;
  assign blocked = uart_store & (state == UART_BUSY) & ~ready & (cnt < TMO);
  assign go      = uart_store & ~blocked;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tmo_nxt   = uart_timeout;
    case (state)
      UART_IDLE: begin
        if (go) begin
          state_nxt = UART_BUSY;
          cnt_nxt   = '0;
        end
      end
      UART_BUSY: begin
        // A store that gets through restarts the wait for the new byte;
        // only one forced through by the counter counts as a timeout.
        if (go) begin
          cnt_nxt = '0;
          if (!ready) tmo_nxt = 1'b1;
        end else if (ready) begin
          state_nxt = UART_IDLE;
        end else if (cnt < TMO) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= UART_IDLE;
      cnt          <= '0;
      uart_timeout <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      uart_timeout <= tmo_nxt;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Single-port MMU front end: data side wins over fetch, one access per clock,
// read data returned one cycle after the grant; UART data stores are paced.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int UART_TIMEOUT = 1024,
  parameter int CNT_W        = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_bytemode,
  output logic [31:0] mem_rdata,
  output logic        mem_valid,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        uart_timeout,
  output logic        mmu_read,
  output logic        mmu_write,
  output logic        mmu_bytemode,
  output logic [31:0] mmu_addr,
  output logic [31:0] mmu_wdata,
  input  logic [31:0] mmu_rdata,
  input  logic        uart_tbre,
  input  logic        uart_tsre
);
  grant_e      grant;
  logic        data_req, uart_store, blocked;
  logic [31:0] rd_hold;

  assign data_req   = mem_read | mem_write;
  assign uart_store = mem_write & is_uart_data(mem_addr);

  uart_tx_pacer #(.UART_TIMEOUT(UART_TIMEOUT), .CNT_W(CNT_W)) u_pacer (
    .clk          (clk),
    .rst          (rst),
    .uart_store   (uart_store),
    .uart_tbre    (uart_tbre),
    .uart_tsre    (uart_tsre),
    .blocked      (blocked),
    .uart_timeout (uart_timeout)
  );

  always_comb begin
    if (data_req && !blocked) grant = GNT_DATA;
    else if (if_req)          grant = GNT_FETCH;
    else                      grant = GNT_IDLE;
  end

  always_comb begin
    mmu_read     = 1'b0;
    mmu_write    = 1'b0;
    mmu_bytemode = 1'b0;
    mmu_addr     = '0;
    mmu_wdata    = '0;
    if (!rst) begin
      case (grant)
        GNT_DATA: begin
          mmu_read     = mem_read & ~mem_write;  // read+write acts as a write
          mmu_write    = mem_write;
          mmu_bytemode = mem_bytemode;
          mmu_addr     = mem_addr;
          mmu_wdata    = mem_wdata;
        end
        GNT_FETCH: begin
          mmu_read = 1'b1;
          mmu_addr = if_addr;
        end
        default: ;
      endcase
    end
  end

  assign stall_if  = if_req & data_req;
  assign stall_mem = blocked;

  // MMU drives its output while clk is high; catch it mid-cycle.
  always_ff @(negedge clk) rd_hold <= mmu_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid  <= 1'b0;
      mem_valid <= 1'b0;
      if_data   <= '0;
      mem_rdata <= '0;
    end else begin
      if_valid  <= (grant == GNT_FETCH);
      mem_valid <= (grant == GNT_DATA);
      if (grant == GNT_FETCH) if_data <= rd_hold;
      if (grant == GNT_DATA && !mem_write) mem_rdata <= rd_hold;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, UART pacing
// sequences, then random traffic against a behavioural reference model.
module tb_mem_arbiter;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_read, mem_write, mem_bytemode, uart_tbre, uart_tsre;
  logic [31:0] if_addr, mem_addr, mem_wdata, mmu_rdata;
  logic [31:0] if_data, mem_rdata, mmu_addr, mmu_wdata;
  logic        if_valid, mem_valid, stall_if, stall_mem, uart_timeout;
  logic        mmu_read, mmu_write, mmu_bytemode;

  mem_arbiter #(.UART_TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_valid(if_valid),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_bytemode(mem_bytemode), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid), .stall_if(stall_if), .stall_mem(stall_mem),
    .uart_timeout(uart_timeout), .mmu_read(mmu_read), .mmu_write(mmu_write),
    .mmu_bytemode(mmu_bytemode), .mmu_addr(mmu_addr), .mmu_wdata(mmu_wdata),
    .mmu_rdata(mmu_rdata), .uart_tbre(uart_tbre), .uart_tsre(uart_tsre)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // reference model state
  bit          m_busy, m_tmo, m_ifv, m_memv;
  int          m_cnt;
  logic [31:0] m_ifd, m_memd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_addr = '0; mem_wdata = '0; mem_bytemode = 1'b0;
  endtask

  // Called 4 time units after a posedge: compare everything with the model,
  // advance the model by one clock, return 1 time unit after the next posedge.
  task automatic model_step();
    bit ready, ustore, blk, dreq, rd, go;
    int g;
    logic e_r, e_w, e_b;
    logic [31:0] e_a, e_wd;
    rd     = mem_read && !mem_write;
    dreq   = mem_read || mem_write;
    ustore = mem_write && mem_addr[29] && !mem_addr[2];
    ready  = uart_tbre && uart_tsre;
    blk    = ustore && m_busy && !ready && (m_cnt < TO);
    g      = (dreq && !blk) ? 2 : (if_req ? 1 : 0);
    e_r = 1'b0; e_w = 1'b0; e_b = 1'b0; e_a = '0; e_wd = '0;
    if (!rst && g == 2) begin
      e_r = rd; e_w = mem_write; e_b = mem_bytemode; e_a = mem_addr; e_wd = mem_wdata;
    end else if (!rst && g == 1) begin
      e_r = 1'b1; e_a = if_addr;
    end
    chk1("mmu_read", mmu_read, e_r);
    chk1("mmu_write", mmu_write, e_w);
    chk1("mmu_bytemode", mmu_bytemode, e_b);
    if (rst || e_r || e_w) chk("mmu_addr", mmu_addr, e_a);
    if (rst || e_w) chk("mmu_wdata", mmu_wdata, e_wd);
    chk1("stall_if", stall_if, if_req && dreq);
    chk1("stall_mem", stall_mem, blk);
    chk1("if_valid", if_valid, m_ifv);
    chk1("mem_valid", mem_valid, m_memv);
    chk("if_data", if_data, m_ifd);
    chk("mem_rdata", mem_rdata, m_memd);
    chk1("uart_timeout", uart_timeout, m_tmo);
    if (rst) begin
      m_busy = 0; m_cnt = 0; m_tmo = 0; m_ifv = 0; m_memv = 0; m_ifd = '0; m_memd = '0;
    end else begin
      m_ifv  = (g == 1);
      m_memv = (g == 2);
      if (g == 1) m_ifd = mmu_rdata;
      if (g == 2 && rd) m_memd = mmu_rdata;
      go = ustore && !blk;
      if (!m_busy) begin
        if (go) begin m_busy = 1; m_cnt = 0; end
      end else if (go) begin
        if (!ready) m_tmo = 1;
        m_cnt = 0;
      end else if (ready) m_busy = 0;
      else if (m_cnt < TO) m_cnt++;
    end
    @(posedge clk); #1;
  endtask

  task automatic tick();
    #3; model_step();
  endtask

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic        bm;
    logic [31:0] rdata;
    logic        e_rd, e_wr, e_bm;
    logic [31:0] e_addr, e_wdata;
    logic        e_sif, e_ifv, e_memv, e_sel;
    logic [31:0] e_data;
  } vec_t;

  vec_t vt[5];

  initial begin
    vt[0] = '{1'b1, 32'h80000000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h2401000F,
              1'b1, 1'b0, 1'b0, 32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h2401000F};
    vt[1] = '{1'b1, 32'h80000010, 1'b1, 1'b0, 32'h80400004, 32'h0, 1'b0, 32'h12345678,
              1'b1, 1'b0, 1'b0, 32'h80400004, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h12345678};
    vt[2] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h80000003, 32'h000000AB, 1'b1, 32'hDEADBEEF,
              1'b0, 1'b1, 1'b1, 32'h80000003, 32'h000000AB, 1'b0, 1'b0, 1'b1, 1'b1, 32'h12345678};
    vt[3] = '{1'b1, 32'h80000020, 1'b1, 1'b1, 32'h80000100, 32'h00000055, 1'b0, 32'hCAFEF00D,
              1'b0, 1'b1, 1'b0, 32'h80000100, 32'h00000055, 1'b1, 1'b0, 1'b1, 1'b1, 32'h12345678};
    // follow-up fetch of vt[3] loads CAFEF00D into if_data
    vt[4] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h11111111,
              1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D};

    rst = 1'b1; idle_inputs(); uart_tbre = 1'b1; uart_tsre = 1'b1; mmu_rdata = '0;
    m_busy = 0; m_cnt = 0; m_tmo = 0; m_ifv = 0; m_memv = 0; m_ifd = '0; m_memd = '0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h80001000;
    #3;
    chk1("rst mmu_read", mmu_read, 1'b0);
    chk("rst mmu_addr", mmu_addr, 32'h0);
    model_step();
    rst = 1'b0; idle_inputs();
    #3;
    chk1("reset if_valid", if_valid, 1'b0);
    chk1("reset mem_valid", mem_valid, 1'b0);
    chk("reset if_data", if_data, 32'h0);
    chk("reset mem_rdata", mem_rdata, 32'h0);
    chk1("reset uart_timeout", uart_timeout, 1'b0);
    model_step();

    // directed vector table
    for (int i = 0; i < 5; i++) begin
      if_req = vt[i].if_req; if_addr = vt[i].if_addr; mem_read = vt[i].rd;
      mem_write = vt[i].wr; mem_addr = vt[i].addr; mem_wdata = vt[i].wdata;
      mem_bytemode = vt[i].bm; mmu_rdata = vt[i].rdata;
      #3;
      chk1($sformatf("v%0d mmu_read", i), mmu_read, vt[i].e_rd);
      chk1($sformatf("v%0d mmu_write", i), mmu_write, vt[i].e_wr);
      chk1($sformatf("v%0d mmu_bytemode", i), mmu_bytemode, vt[i].e_bm);
      chk($sformatf("v%0d mmu_addr", i), mmu_addr, vt[i].e_addr);
      if (vt[i].e_wr) chk($sformatf("v%0d mmu_wdata", i), mmu_wdata, vt[i].e_wdata);
      chk1($sformatf("v%0d stall_if", i), stall_if, vt[i].e_sif);
      model_step();
      mem_read = 1'b0; mem_write = 1'b0; mem_bytemode = 1'b0;
      #3;
      chk1($sformatf("v%0d if_valid", i), if_valid, vt[i].e_ifv);
      chk1($sformatf("v%0d mem_valid", i), mem_valid, vt[i].e_memv);
      chk($sformatf("v%0d data", i), vt[i].e_sel ? mem_rdata : if_data, vt[i].e_data);
      if (vt[i].if_req) begin
        chk1($sformatf("v%0d held fetch", i), mmu_read, 1'b1);
        chk($sformatf("v%0d held fetch addr", i), mmu_addr, vt[i].if_addr);
      end
      model_step();
    end
    idle_inputs();

    // UART: second store waits for tbre&tsre
    uart_tbre = 1'b0; uart_tsre = 1'b0;
    mem_write = 1'b1; mem_addr = 32'hBFD003F8; mem_wdata = 32'h41;
    #3;
    chk1("uart1 granted", mmu_write, 1'b1);
    chk1("uart1 stall_mem", stall_mem, 1'b0);
    model_step();
    mem_wdata = 32'h42;
    for (int k = 0; k < 3; k++) begin
      #3;
      chk1("uart2 stall_mem", stall_mem, 1'b1);
      chk1("uart2 held", mmu_write, 1'b0);
      model_step();
    end
    uart_tbre = 1'b1; uart_tsre = 1'b1;
    #3;
    chk1("uart2 release stall", stall_mem, 1'b0);
    chk("uart2 release wdata", mmu_wdata, 32'h42);
    model_step();
    uart_tbre = 1'b0;
    mem_write = 1'b0; mem_read = 1'b1; mem_addr = 32'hBFD003FC;
    #3;
    chk1("status read in busy", mmu_read, 1'b1);
    model_step();

    // UART timeout
    idle_inputs(); rst = 1'b1; tick(); rst = 1'b0;
    uart_tbre = 1'b0; uart_tsre = 1'b0;
    mem_write = 1'b1; mem_addr = 32'hBFD003F8; mem_wdata = 32'h31;
    #3;
    chk1("tmo store1", mmu_write, 1'b1);
    model_step();
    mem_wdata = 32'h32;
    begin
      int nb;
      nb = 0;
      for (int k = 0; k < 20; k++) begin
        #3;
        if (stall_mem !== 1'b1) break;
        nb++;
        model_step();
      end
      chk("tmo blocked cycles", nb, 32'd8);
      chk1("tmo store2 granted", mmu_write, 1'b1);
      model_step();
    end
    mem_write = 1'b0;
    #3;
    chk1("tmo flag set", uart_timeout, 1'b1);
    model_step();
    rst = 1'b1; tick(); rst = 1'b0;
    #3;
    chk1("tmo flag cleared", uart_timeout, 1'b0);
    model_step();

    // reset while BUSY cancels the wait
    mem_write = 1'b1; mem_wdata = 32'h51;
    tick();
    mem_write = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; mem_write = 1'b1; mem_wdata = 32'h52;
    #3;
    chk1("post-rst store stall", stall_mem, 1'b0);
    chk1("post-rst store granted", mmu_write, 1'b1);
    model_step();

    // random traffic
    idle_inputs();
    for (int n = 0; n < 600; n++) begin
      rst          = ($urandom_range(0, 59) == 0);
      if_req       = 1'($urandom_range(0, 1));
      if_addr      = $urandom;
      mem_read     = ($urandom_range(0, 2) == 0);
      mem_write    = ($urandom_range(0, 1) == 0);
      mem_bytemode = 1'($urandom_range(0, 1));
      mem_wdata    = $urandom;
      mmu_rdata    = $urandom;
      uart_tbre    = ($urandom_range(0, 4) == 0);
      uart_tsre    = ($urandom_range(0, 1) == 0);
      case ($urandom_range(0, 3))
        0: mem_addr = 32'hBFD003F8;
        1: mem_addr = 32'hBFD003FC;
        2: mem_addr = 32'hBFD003F8;
        default: mem_addr = 32'h80000000 | ($urandom & 32'h00FFFFFF);
      endcase
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
